lcd_hex_formatter: RTL and testbench



---
 rtl/lcd_fmt_pkg.sv | 25 ++
 rtl/lcd_hex_char.sv | 14 +
 rtl/lcd_hex_formatter.sv | 169 ++++++++++++++++
 tb/tb_lcd_hex_formatter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_fmt_pkg.sv
// Shared types, widths and the nibble-to-ASCII encoder for the LCD hex formatter.
// Contents: character geometry (CHAR_W, LCD_CHARS, STR_W, POS_W), FSM state enum,
// and nib_to_ascii (0-9 -> '0'-'9', a-f lowercase).
package lcd_fmt_pkg;

    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned LCD_CHARS = 32;
    localparam int unsigned STR_W     = CHAR_W * LCD_CHARS;
    localparam int unsigned POS_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        PULSE = 2'd2
    } state_t;

    // 0x61 - 10 = 0x57, so nibbles 10..15 land on 'a'..'f'
    function automatic logic [CHAR_W-1:0] nib_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/lcd_hex_char.sv
// Combinational hex digit encoder: one nibble in, one lowercase ASCII character out.
// Ports: nib (4-bit value), ascii_c (8-bit character code).
module lcd_hex_char
    import lcd_fmt_pkg::*;
(
    input  logic [3:0]        nib,
    output logic [CHAR_W-1:0] ascii_c
);

    always_comb begin
        ascii_c = nib_to_ascii(nib);
    end

endmodule

// File: rtl/lcd_hex_formatter.sv
// Sequential hex formatter for the 32-character LCD string. Snapshots NCH channel
// values plus a page select, then writes one character per cycle into str and
// pulses refresh once the string has settled.
// Ports: clk, rst (sync, active-high), ch_val (NCH*W channel values), page (nibble
// window), force_scan (rewrite request), str (256-bit string, char i at
// str[255-8i -: 8]), refresh (one-cycle strobe), busy (state != IDLE).
module lcd_hex_formatter
    import lcd_fmt_pkg::*;
#(
    parameter int unsigned          NCH      = 4,
    parameter int unsigned          W        = 32,
    parameter int unsigned          NIB      = 4,
    parameter logic [NCH*POS_W-1:0] POS      = {5'd12, 5'd8, 5'd4, 5'd0},
    parameter logic [STR_W-1:0]     INIT_STR = "01234567 00 0123f01d01e01m01w01 ",
    localparam int unsigned         PAGES    = W / (4 * NIB),
    localparam int unsigned         PW       = (PAGES > 1) ? $clog2(PAGES) : 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*W-1:0]   ch_val,
    input  logic [PW-1:0]      page,
    input  logic               force_scan,
    output logic [STR_W-1:0]   str,
    output logic               refresh,
    output logic               busy
);

    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned DG_W  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned FW    = 4 * NIB;
    localparam int unsigned IDX_W = POS_W + 1;

    state_t           state, state_d;
    logic [NCH*W-1:0] snap_val, snap_val_d;
    logic [PW-1:0]    snap_page, snap_page_d;
    logic             dirty, dirty_d;
    logic [CH_W-1:0]  chan, chan_d;
    logic [DG_W-1:0]  dig, dig_d;
    logic             refresh_d;
    logic             busy_d;
    logic             wr_c;

    logic [W-1:0]        chan_word_c;
    logic [FW-1:0]       window_c;
    logic [3:0]          nib_c;
    logic [POS_W-1:0]    base_c;
    logic [IDX_W-1:0]    char_idx_c;
    logic [CHAR_W-1:0]   ascii_c;

    // Scan mux: pick the snapshot nibble and target position for (chan, dig).
    // Unmatched page values fall through to the page-0 default window.
    always_comb begin
        chan_word_c = snap_val[W-1:0];
        base_c      = POS[POS_W-1:0];
        for (int unsigned c = 0; c < NCH; c++) begin
            if (chan == CH_W'(c)) begin
                chan_word_c = snap_val[c*W +: W];
                base_c      = POS[c*POS_W +: POS_W];
            end
        end

        window_c = chan_word_c[FW-1:0];
        for (int unsigned p = 0; p < PAGES; p++) begin
            if (snap_page == PW'(p)) begin
                window_c = chan_word_c[p*FW +: FW];
            end
        end

        // digit 0 is the most significant nibble of the window
        nib_c = window_c[FW-1 -: 4];
        for (int unsigned d = 0; d < NIB; d++) begin
            if (dig == DG_W'(d)) begin
                nib_c = window_c[(NIB-1-d)*4 +: 4];
            end
        end

        // one extra bit so positions past the last character are never aliased
        char_idx_c = {1'b0, base_c} + IDX_W'(dig);
    end

    lcd_hex_char u_char (
        .nib     (nib_c),
        .ascii_c (ascii_c)
    );

    // Next-state, snapshot and counter logic.
    always_comb begin
        state_d     = state;
        snap_val_d  = snap_val;
        snap_page_d = snap_page;
        dirty_d     = dirty;
        chan_d      = chan;
        dig_d       = dig;
        refresh_d   = 1'b0;
        wr_c        = 1'b0;

        unique case (state)
            IDLE: begin
                if (dirty || force_scan || (ch_val != snap_val) || (page != snap_page)) begin
                    snap_val_d  = ch_val;
                    snap_page_d = page;
                    dirty_d     = 1'b0;
                    chan_d      = '0;
                    dig_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                wr_c = 1'b1;
                if (dig == DG_W'(NIB - 1)) begin
                    dig_d = '0;
                    if (chan == CH_W'(NCH - 1)) begin
                        state_d   = PULSE;
                        refresh_d = 1'b1;
                    end else begin
                        chan_d = chan + CH_W'(1);
                    end
                end else begin
                    dig_d = dig + DG_W'(1);
                end
            end
            PULSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, snapshot and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snap_val  <= '0;
            snap_page <= '0;
            dirty     <= 1'b1;
            chan      <= '0;
            dig       <= '0;
            refresh   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            snap_val  <= snap_val_d;
            snap_page <= snap_page_d;
            dirty     <= dirty_d;
            chan      <= chan_d;
            dig       <= dig_d;
            refresh   <= refresh_d;
            busy      <= busy_d;
        end
    end

    // String register: only SCAN cycles write, and only in-range positions.
    always_ff @(posedge clk) begin
        if (rst) begin
            str <= INIT_STR;
        end else if (wr_c) begin
            for (int unsigned i = 0; i < LCD_CHARS; i++) begin
                if (char_idx_c == IDX_W'(i)) begin
                    str[STR_W-1-CHAR_W*i -: CHAR_W] <= ascii_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_hex_formatter.sv
// Directed bench for lcd_hex_formatter: default configuration, a 2-channel byte
// configuration, and a 1-channel 3-page configuration placed at the string's end.
module tb_lcd_hex_formatter;

    localparam logic [255:0] INIT = "01234567 00 0123f01d01e01m01w01 ";

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic         rst;
    logic [127:0] ch_val;
    logic [0:0]   page;
    logic         force_scan;
    logic [255:0] str;
    logic         refresh;
    logic         busy;

    // NCH=2, W=16, NIB=2, fields at 0 and 30
    logic         rst_aux;
    logic [31:0]  ch2;
    logic [0:0]   page2;
    logic         force2;
    logic [255:0] str2;
    logic         refresh2;
    logic         busy2;

    // NCH=1, W=48, NIB=4, field at 30 (digits 2,3 fall off the end)
    logic [47:0]  ch3;
    logic [1:0]   page3;
    logic         force3;
    logic [255:0] str3;
    logic         refresh3;
    logic         busy3;

    int errors = 0;
    int checks = 0;
    int ref1 = 0;
    int ref2 = 0;
    int ref3 = 0;

    lcd_hex_formatter dut (
        .clk        (clk),
        .rst        (rst),
        .ch_val     (ch_val),
        .page       (page),
        .force_scan (force_scan),
        .str        (str),
        .refresh    (refresh),
        .busy       (busy)
    );

    lcd_hex_formatter #(
        .NCH (2),
        .W   (16),
        .NIB (2),
        .POS ({5'd30, 5'd0})
    ) dut2 (
        .clk        (clk),
        .rst        (rst_aux),
        .ch_val     (ch2),
        .page       (page2),
        .force_scan (force2),
        .str        (str2),
        .refresh    (refresh2),
        .busy       (busy2)
    );

    lcd_hex_formatter #(
        .NCH (1),
        .W   (48),
        .NIB (4),
        .POS (5'd30)
    ) dut3 (
        .clk        (clk),
        .rst        (rst_aux),
        .ch_val     (ch3),
        .page       (page3),
        .force_scan (force3),
        .str        (str3),
        .refresh    (refresh3),
        .busy       (busy3)
    );

    always @(negedge clk) begin
        if (refresh)  ref1++;
        if (refresh2) ref2++;
        if (refresh3) ref3++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first;
        int r0;
        rst = 1'b1; rst_aux = 1'b1;
        ch_val = '0; page = '0; force_scan = 1'b0;
        ch2 = '0; page2 = '0; force2 = 1'b0;
        ch3 = '0; page3 = '0; force3 = 1'b0;
        repeat (3) tick();
        checks++; if (str !== INIT) begin errors++; $display("FAIL reset_str: got %s exp %s", str, INIT); end
        checks++; if (refresh !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: refresh=%b busy=%b exp 0 0", refresh, busy); end
        checks++; if (str2 !== INIT || str3 !== INIT) begin errors++; $display("FAIL reset_aux_str: got %s / %s exp %s", str2, str3, INIT); end
        r0 = ref1;
        first = 0;
        rst = 1'b0; rst_aux = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (refresh === 1'b1 && first == 0) first = k;
            if (k == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_rise: got %b exp 1", busy); end
            end
            if (k == 18) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_fall: got %b exp 0", busy); end
            end
        end
        checks++; if (first != 17) begin errors++; $display("FAIL reset_refresh_latency: got %0d exp 17", first); end
        checks++; if (ref1 - r0 != 1) begin errors++; $display("FAIL reset_refresh_count: got %0d exp 1", ref1 - r0); end
        checks++; if (str !== 256'("0000000000000000f01d01e01m01w01 ")) begin errors++; $display("FAIL reset_scan_str: got %s", str); end
        checks++; if (str2 !== 256'("00234567 00 0123f01d01e01m01w000")) begin errors++; $display("FAIL reset_scan_str2: got %s", str2); end
        checks++; if (str3 !== 256'("01234567 00 0123f01d01e01m01w000")) begin errors++; $display("FAIL reset_scan_str3: got %s", str3); end
    endtask

    task automatic test_page_window();
        int r0;
        r0 = ref1;
        ch_val[31:0] = 32'h1234ABCD;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                checks++; if (str[255 -: 8] !== 8'h30) begin errors++; $display("FAIL page_char0_before: got %h exp 30", str[255 -: 8]); end
            end
            if (k == 2) begin
                checks++; if (str[255 -: 8] !== 8'h61) begin errors++; $display("FAIL page_char0_first_edge: got %h exp 61", str[255 -: 8]); end
            end
        end
        checks++; if (str !== 256'("abcd000000000000f01d01e01m01w01 ")) begin errors++; $display("FAIL page0_str: got %s", str); end
        page = 1'b1;
        repeat (20) tick();
        checks++; if (str !== 256'("1234000000000000f01d01e01m01w01 ")) begin errors++; $display("FAIL page1_str: got %s", str); end
        checks++; if (ref1 - r0 != 2) begin errors++; $display("FAIL page_refresh_count: got %0d exp 2", ref1 - r0); end

        r0 = ref3;
        ch3 = 48'h0000_1234_ABCD;
        page3 = 2'd3;
        repeat (20) tick();
        checks++; if (str3 !== 256'("01234567 00 0123f01d01e01m01w0ab")) begin errors++; $display("FAIL page_oob_str: got %s", str3); end
        checks++; if (ref3 - r0 != 1) begin errors++; $display("FAIL page_oob_refresh: got %0d exp 1", ref3 - r0); end
        page3 = 2'd1;
        repeat (20) tick();
        checks++; if (str3 !== 256'("01234567 00 0123f01d01e01m01w012")) begin errors++; $display("FAIL page3_p1_str: got %s", str3); end
        page3 = 2'd2;
        repeat (20) tick();
        checks++; if (str3 !== 256'("01234567 00 0123f01d01e01m01w000")) begin errors++; $display("FAIL page3_p2_str: got %s", str3); end
    endtask

    task automatic test_change_during_scan();
        int r0;
        r0 = ref1;
        page = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 3) ch_val[63:32] = 32'h0000_9F00;
            if (k == 17) begin
                checks++; if (refresh !== 1'b1) begin errors++; $display("FAIL chg_refresh1: got %b exp 1", refresh); end
                checks++; if (str !== 256'("abcd000000000000f01d01e01m01w01 ")) begin errors++; $display("FAIL chg_first_scan_str: got %s", str); end
            end
            if (k == 18) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chg_idle_gap: busy=%b exp 0", busy); end
            end
            if (k == 35) begin
                checks++; if (refresh !== 1'b1) begin errors++; $display("FAIL chg_refresh2: got %b exp 1", refresh); end
                checks++; if (str !== 256'("abcd9f0000000000f01d01e01m01w01 ")) begin errors++; $display("FAIL chg_second_scan_str: got %s", str); end
            end
        end
        checks++; if (ref1 - r0 != 2) begin errors++; $display("FAIL chg_refresh_count: got %0d exp 2", ref1 - r0); end
    endtask

    task automatic test_force();
        int r0;
        int first;
        int hits [3];
        int n;
        r0 = ref1;
        first = 0;
        force_scan = 1'b1;
        tick();
        force_scan = 1'b0;
        for (int k = 2; k <= 25; k++) begin
            tick();
            if (refresh === 1'b1 && first == 0) first = k;
        end
        checks++; if (first != 17) begin errors++; $display("FAIL force_pulse_latency: got %0d exp 17", first); end
        checks++; if (ref1 - r0 != 1) begin errors++; $display("FAIL force_pulse_count: got %0d exp 1", ref1 - r0); end
        checks++; if (str !== 256'("abcd9f0000000000f01d01e01m01w01 ")) begin errors++; $display("FAIL force_pulse_str: got %s", str); end

        n = 0;
        hits = '{0, 0, 0};
        force_scan = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 40) force_scan = 1'b0;
            if (refresh === 1'b1) begin
                if (n < 3) hits[n] = k;
                n++;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL force_held_count: got %0d exp 3", n); end
        checks++; if (hits[0] != 17 || hits[1] != 35 || hits[2] != 53) begin
            errors++; $display("FAIL force_held_spacing: got %0d %0d %0d exp 17 35 53", hits[0], hits[1], hits[2]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int r0;
        int first;
        r0 = ref1;
        ch_val[31:0] = 32'hFFFF_FFFF;
        for (int k = 1; k <= 9; k++) tick();
        checks++; if (busy !== 1'b1 || str !== 256'("ffff9f0000000000f01d01e01m01w01 ")) begin
            errors++; $display("FAIL midscan_pre: busy=%b str=%s", busy, str);
        end
        rst = 1'b1;
        tick();
        checks++; if (str !== INIT) begin errors++; $display("FAIL midscan_rst_str: got %s exp %s", str, INIT); end
        checks++; if (refresh !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midscan_rst_flags: refresh=%b busy=%b exp 0 0", refresh, busy); end
        tick();
        rst = 1'b0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (refresh === 1'b1 && first == 0) first = k;
        end
        checks++; if (first != 17) begin errors++; $display("FAIL midscan_rescan_latency: got %0d exp 17", first); end
        checks++; if (ref1 - r0 != 1) begin errors++; $display("FAIL midscan_refresh_count: got %0d exp 1", ref1 - r0); end
        checks++; if (str !== 256'("ffff9f0000000000f01d01e01m01w01 ")) begin errors++; $display("FAIL midscan_final_str: got %s", str); end
    endtask

    task automatic test_small_config();
        int r0;
        int first;
        r0 = ref2;
        ch2 = {16'hBEEF, 16'h00C3};
        page2 = 1'b0;
        repeat (10) tick();
        checks++; if (str2 !== 256'("c3234567 00 0123f01d01e01m01w0ef")) begin errors++; $display("FAIL small_page0_str: got %s", str2); end
        page2 = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (refresh2 === 1'b1 && first == 0) first = k;
        end
        checks++; if (first != 5) begin errors++; $display("FAIL small_refresh_latency: got %0d exp 5", first); end
        checks++; if (str2 !== 256'("00234567 00 0123f01d01e01m01w0be")) begin errors++; $display("FAIL small_page1_str: got %s", str2); end
        checks++; if (ref2 - r0 != 2) begin errors++; $display("FAIL small_refresh_count: got %0d exp 2", ref2 - r0); end
    endtask

    initial begin
        test_reset();
        test_page_window();
        test_change_during_scan();
        test_force();
        test_reset_mid_scan();
        test_small_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
